// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one valid/grant data-memory transaction per memory
// instruction, formats store lanes and strobes, aligns and extends load data for writeback.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] exmem_op_c_i,
  input  logic [4:0]  exmem_reg_waddr_i,
  input  logic        exmem_reg_we_i,
  input  logic        exmem_mtype_i,
  input  logic        exmem_mem_rw_i,
  input  logic [1:0]  exmem_mem_width_i,
  input  logic [31:0] exmem_mem_wr_data_i,
  input  logic        exmem_mem_rdtype_i,
  input  logic [31:0] exmem_mem_addr_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic [3:0]  dm_wstrb_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic        mem_stall_o,
  output logic        mem_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    lsb_q, lsb_d;
  logic [1:0]    width_q, width_d;
  logic          rdtype_q, rdtype_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          misaligned;
  logic          mem_ok;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [31:0]   lane;
  logic [31:0]   ld_data;

  always_comb begin
    misaligned = 1'b0;
    if (exmem_mtype_i) begin
      case (exmem_mem_width_i)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = exmem_mem_addr_i[0];
        default: misaligned = |exmem_mem_addr_i[1:0];
      endcase
    end
  end

  assign mem_ok = exmem_mtype_i & ~misaligned;

  always_comb begin
    case (exmem_mem_width_i)
      2'b00: begin
        st_wdata = {4{exmem_mem_wr_data_i[7:0]}};
        st_wstrb = 4'b0001 << exmem_mem_addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{exmem_mem_wr_data_i[15:0]}};
        st_wstrb = exmem_mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = exmem_mem_wr_data_i;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load shaping uses the attributes latched at request time, not the live EX/MEM inputs.
  assign lane = dm_rdata_i >> {lsb_q, 3'b000};

  always_comb begin
    case (width_q)
      2'b00:   ld_data = rdtype_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_data = rdtype_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = dm_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      lsb_q    <= '0;
      width_q  <= '0;
      rdtype_q <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      lsb_q    <= lsb_d;
      width_q  <= width_d;
      rdtype_q <= rdtype_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    lsb_d    = lsb_q;
    width_d  = width_q;
    rdtype_d = rdtype_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ok) begin
          state_d  = REQ;
          req_d    = 1'b1;
          we_d     = exmem_mem_rw_i;
          addr_d   = {exmem_mem_addr_i[31:2], 2'b00};
          wdata_d  = st_wdata;
          wstrb_d  = st_wstrb;
          lsb_d    = exmem_mem_addr_i[1:0];
          width_d  = exmem_mem_width_i;
          rdtype_d = exmem_mem_rdtype_i;
        end else if (exmem_mtype_i) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        if (dm_gnt_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dm_rvalid_i) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_stall_o     = mem_ok & (state_q != DONE);
    mem_reg_waddr_o = exmem_reg_waddr_i;
    mem_reg_wdata_o = exmem_op_c_i;
    mem_reg_we_o    = exmem_reg_we_i;
    if (exmem_mtype_i) begin
      mem_reg_wdata_o = rdata_q;
      mem_reg_we_o    = mem_ok & ~exmem_mem_rw_i & exmem_reg_we_i & (state_q == DONE);
    end
  end

  assign dm_req_o   = req_q;
  assign dm_we_o    = we_q;
  assign dm_addr_o  = addr_q;
  assign dm_wdata_o = wdata_q;
  assign dm_wstrb_o = wstrb_q;
  assign mem_err_o  = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected writeback pushed at issue, popped at DONE.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] exmem_op_c_i;
  logic [4:0]  exmem_reg_waddr_i;
  logic        exmem_reg_we_i;
  logic        exmem_mtype_i;
  logic        exmem_mem_rw_i;
  logic [1:0]  exmem_mem_width_i;
  logic [31:0] exmem_mem_wr_data_i;
  logic        exmem_mem_rdtype_i;
  logic [31:0] exmem_mem_addr_i;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic [3:0]  dm_wstrb_o;
  logic        dm_gnt_i, dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic [31:0] mem_reg_wdata_o;
  logic [4:0]  mem_reg_waddr_o;
  logic        mem_reg_we_o, mem_stall_o, mem_err_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .exmem_op_c_i(exmem_op_c_i), .exmem_reg_waddr_i(exmem_reg_waddr_i),
    .exmem_reg_we_i(exmem_reg_we_i), .exmem_mtype_i(exmem_mtype_i),
    .exmem_mem_rw_i(exmem_mem_rw_i), .exmem_mem_width_i(exmem_mem_width_i),
    .exmem_mem_wr_data_i(exmem_mem_wr_data_i), .exmem_mem_rdtype_i(exmem_mem_rdtype_i),
    .exmem_mem_addr_i(exmem_mem_addr_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_wstrb_o(dm_wstrb_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .mem_reg_wdata_o(mem_reg_wdata_o), .mem_reg_waddr_o(mem_reg_waddr_o),
    .mem_reg_we_o(mem_reg_we_o), .mem_stall_o(mem_stall_o), .mem_err_o(mem_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic        we;
    int          stall;
    int          errs;
  } exp_t;
  exp_t exp_q[$];

  // Observations of the most recent transaction.
  logic [31:0] obs_addr, obs_wdata, obs_res;
  logic [3:0]  obs_wstrb;
  logic        obs_we, obs_res_we, obs_unstable, obs_done, obs_req_seen;
  logic [4:0]  obs_waddr;
  int          obs_stall, obs_errs;

  function automatic logic [31:0] m_store_data(input logic [1:0] w, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[7:0];
    h = d[15:0];
    if (w == 2'b00) return {b, b, b, b};
    if (w == 2'b01) return {h, h};
    return d;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] w, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (w == 2'b00) s[a] = 1'b1;
    else if (w == 2'b01) begin s[{a[1], 1'b0}] = 1'b1; s[{a[1], 1'b1}] = 1'b1; end
    else s = 4'b1111;
    return s;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] w, input logic zx,
                                         input logic [1:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[8*a +: 8];
    h = r[8*a +: 16];
    if (w == 2'b00) return zx ? {24'h0, b} : {{24{b[7]}}, b};
    if (w == 2'b01) return zx ? {16'h0, h} : {{16{h[15]}}, h};
    return r;
  endfunction

  task automatic set_nop(input logic [31:0] opc, input logic rwe);
    exmem_mtype_i = 1'b0; exmem_mem_rw_i = 1'b0; exmem_mem_width_i = 2'b00;
    exmem_mem_addr_i = 32'h0; exmem_mem_wr_data_i = 32'h0; exmem_mem_rdtype_i = 1'b0;
    exmem_op_c_i = opc; exmem_reg_we_i = rwe; exmem_reg_waddr_i = 5'd0;
  endtask

  // Presents one memory instruction and plays the memory side; gd = grant delay in REQ
  // cycles, rd = rvalid delay in WAIT cycles (-1 = never).
  task automatic do_txn(input logic rw, input logic [1:0] w, input logic zx,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input logic rwe, input logic [4:0] wa, input int gd, input int rd);
    int nreq = 0;
    int nwait = 0;
    logic granted = 1'b0;
    logic fin = 1'b0;
    @(posedge clk); #1;
    exmem_mtype_i = 1'b1; exmem_mem_rw_i = rw; exmem_mem_width_i = w; exmem_mem_rdtype_i = zx;
    exmem_mem_addr_i = addr; exmem_mem_wr_data_i = sdata; exmem_reg_we_i = rwe;
    exmem_reg_waddr_i = wa; exmem_op_c_i = 32'hDEAD_BEEF;
    obs_stall = 0; obs_errs = 0; obs_unstable = 1'b0; obs_req_seen = 1'b0;
    obs_res = 32'hx; obs_res_we = 1'bx; obs_addr = 32'h0; obs_wdata = 32'h0;
    obs_wstrb = 4'h0; obs_we = 1'b0; obs_waddr = mem_reg_waddr_o;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = $urandom;
      if (mem_err_o) obs_errs++;
      if (!mem_stall_o) begin
        obs_res = mem_reg_wdata_o; obs_res_we = mem_reg_we_o; fin = 1'b1;
      end else begin
        obs_stall++;
        if (dm_req_o) begin
          if (!obs_req_seen) begin
            obs_addr = dm_addr_o; obs_wdata = dm_wdata_o; obs_wstrb = dm_wstrb_o; obs_we = dm_we_o;
          end else if (dm_addr_o !== obs_addr || dm_wdata_o !== obs_wdata ||
                       dm_wstrb_o !== obs_wstrb || dm_we_o !== obs_we) begin
            obs_unstable = 1'b1;
          end
          obs_req_seen = 1'b1;
          if (nreq == gd) begin dm_gnt_i = 1'b1; granted = 1'b1; end
          nreq++;
        end else if (granted) begin
          if (nwait == rd) begin dm_rvalid_i = 1'b1; dm_rdata_i = rdata; end
          nwait++;
        end
      end
    end
    obs_done = fin;
    @(posedge clk); #1;
    set_nop(32'h0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_nop(32'h0, 1'b0);
    dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; dm_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (dm_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", dm_req_o); end
    n_cmp++; if (dm_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", dm_we_o); end
    n_cmp++; if ({dm_addr_o, dm_wdata_o, dm_wstrb_o} !== 68'h0) begin n_bad++;
      $display("FAIL rst_bus got addr %h wdata %h strb %b want zeros", dm_addr_o, dm_wdata_o, dm_wstrb_o); end
    n_cmp++; if ({mem_err_o, mem_stall_o} !== 2'b00) begin n_bad++;
      $display("FAIL rst_err_stall got %b%b want 00", mem_err_o, mem_stall_o); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: req=%b addr=%h err=%b", dm_req_o, dm_addr_o, mem_err_o);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    e = exp_q.pop_front();
    n_cmp++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL %s_done got %b want 1 (cycle budget)", name, obs_done); end
    n_cmp++; if (obs_stall != e.stall) begin n_bad++; $display("FAIL %s_stall got %0d want %0d", name, obs_stall, e.stall); end
    n_cmp++; if (obs_res_we !== e.we) begin n_bad++; $display("FAIL %s_we got %b want %b", name, obs_res_we, e.we); end
    n_cmp++; if (obs_errs != e.errs) begin n_bad++; $display("FAIL %s_err got %0d want %0d", name, obs_errs, e.errs); end
    if (e.chk_res) begin
      n_cmp++; if (obs_res !== e.res) begin n_bad++; $display("FAIL %s_res got %h want %h", name, obs_res, e.res); end
    end
    $display("%s: stall=%0d we=%b res=%h err=%0d addr=%h strb=%b", name, obs_stall, obs_res_we, obs_res, obs_errs, obs_addr, obs_wstrb);
  endtask

  task automatic test_store_byte;
    exp_q.push_back('{res: 32'h0, chk_res: 1'b0, we: 1'b0, stall: 2, errs: 0});
    do_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 1'b1, 5'd9, 0, 0);
    n_cmp++; if (obs_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got %h want a5a5a5a5", obs_wdata); end
    n_cmp++; if (obs_wstrb !== 4'b1000) begin n_bad++; $display("FAIL sb_wstrb got %b want 1000", obs_wstrb); end
    n_cmp++; if (obs_addr !== 32'h100) begin n_bad++; $display("FAIL sb_addr got %h want 00000100", obs_addr); end
    n_cmp++; if (obs_we !== 1'b1) begin n_bad++; $display("FAIL sb_dm_we got %b want 1", obs_we); end
    n_cmp++; if (obs_waddr !== 5'd9) begin n_bad++; $display("FAIL sb_waddr got %0d want 9", obs_waddr); end
    check_pop("store_byte");
  endtask

  task automatic test_load_byte;
    exp_q.push_back('{res: 32'hFFFF_FF80, chk_res: 1'b1, we: 1'b1, stall: 3, errs: 0});
    do_txn(1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 32'h0080_FF00, 1'b1, 5'd3, 0, 0);
    check_pop("load_byte");
  endtask

  task automatic test_load_half_delayed;
    exp_q.push_back('{res: 32'h0000_8001, chk_res: 1'b1, we: 1'b1, stall: 6, errs: 0});
    do_txn(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h8001_0000, 1'b1, 5'd4, 3, 0);
    n_cmp++; if (obs_unstable !== 1'b0) begin n_bad++; $display("FAIL lhu_stable got unstable=%b want 0", obs_unstable); end
    n_cmp++; if ({obs_addr, obs_we} !== {32'h300, 1'b0}) begin n_bad++;
      $display("FAIL lhu_req got addr %h we %b want 00000300 0", obs_addr, obs_we); end
    check_pop("load_half_delayed");
  endtask

  task automatic test_misaligned;
    int errs = 0;
    int reqs = 0;
    @(posedge clk); #1;
    exmem_mtype_i = 1'b1; exmem_mem_rw_i = 1'b0; exmem_mem_width_i = 2'b10;
    exmem_mem_addr_i = 32'h401; exmem_reg_we_i = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_stall_o, mem_reg_we_o} !== 2'b00) begin n_bad++;
      $display("FAIL mis_stall_we got %b%b want 00", mem_stall_o, mem_reg_we_o); end
    errs += int'(mem_err_o); reqs += int'(dm_req_o);
    @(posedge clk); #1;
    set_nop(32'h0, 1'b0);
    repeat (3) begin @(negedge clk); errs += int'(mem_err_o); reqs += int'(dm_req_o); end
    n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL mis_err_pulse got %0d cycles want 1", errs); end
    n_cmp++; if (reqs != 0) begin n_bad++; $display("FAIL mis_req got %0d cycles want 0", reqs); end
    $display("misaligned: err_cycles=%0d req_cycles=%0d", errs, reqs);
  endtask

  task automatic test_timeout;
    exp_q.push_back('{res: 32'h0, chk_res: 1'b1, we: 1'b1, stall: 18, errs: 1});
    do_txn(1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 32'h0, 1'b1, 5'd5, 0, -1);
    @(negedge clk);
    n_cmp++; if ({mem_err_o, dm_req_o, mem_stall_o} !== 3'b000) begin n_bad++;
      $display("FAIL to_after got err/req/stall %b%b%b want 000", mem_err_o, dm_req_o, mem_stall_o); end
    check_pop("timeout");
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    exmem_mtype_i = 1'b1; exmem_mem_rw_i = 1'b0; exmem_mem_width_i = 2'b10;
    exmem_mem_addr_i = 32'h500; exmem_reg_we_i = 1'b1;
    @(negedge clk);
    @(negedge clk); dm_gnt_i = 1'b1;
    @(negedge clk); dm_gnt_i = 1'b0;
    rst_n = 1'b0;
    set_nop(32'h0, 1'b0);
    #1;
    n_cmp++; if ({dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, mem_err_o, mem_stall_o} !== 40'h0) begin n_bad++;
      $display("FAIL rmid_outputs got req %b we %b addr %h strb %b err %b stall %b want zeros",
               dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, mem_err_o, mem_stall_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); dm_rvalid_i = 1'b1; dm_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk); dm_rvalid_i = 1'b0;
    n_cmp++; if ({dm_req_o, mem_stall_o, mem_err_o} !== 3'b000) begin n_bad++;
      $display("FAIL rmid_stray got req/stall/err %b%b%b want 000", dm_req_o, mem_stall_o, mem_err_o); end
    @(posedge clk); #1;
    set_nop(32'h1234, 1'b1);
    exmem_reg_waddr_i = 5'd7;
    @(negedge clk);
    n_cmp++; if ({mem_reg_wdata_o, mem_reg_we_o, mem_stall_o} !== {32'h1234, 1'b1, 1'b0}) begin n_bad++;
      $display("FAIL alu_pass got wdata %h we %b stall %b want 00001234 1 0", mem_reg_wdata_o, mem_reg_we_o, mem_stall_o); end
    $display("reset_mid: alu wdata=%h we=%b", mem_reg_wdata_o, mem_reg_we_o);
    exp_q.push_back('{res: 32'hCAFE_F00D, chk_res: 1'b1, we: 1'b1, stall: 3, errs: 0});
    do_txn(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'hCAFE_F00D, 1'b1, 5'd2, 0, 0);
    check_pop("post_reset_lw");
  endtask

  task automatic test_random_mix;
    for (int i = 0; i < 10; i++) begin
      logic        rw, zx, rwe;
      logic [1:0]  w, lsb;
      logic [31:0] addr, sd, rdat;
      int          gd, rd;
      rw = 1'($urandom); zx = 1'($urandom); rwe = 1'($urandom);
      w = 2'($urandom_range(0, 3));
      lsb = 2'($urandom);
      if (w == 2'b01) lsb[0] = 1'b0;
      if (w[1]) lsb = 2'b00;
      addr = {$urandom, 2'b00} | {30'h0, lsb};
      sd = $urandom; rdat = $urandom;
      gd = $urandom_range(0, 2); rd = $urandom_range(0, 2);
      exp_q.push_back('{res: m_load(w, zx, lsb, rdat), chk_res: !rw, we: !rw && rwe,
                        stall: 2 + gd + (rw ? 0 : rd + 1), errs: 0});
      do_txn(rw, w, zx, addr, sd, rdat, rwe, 5'(i), gd, rd);
      n_cmp++; if (obs_addr !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL mix%0d_addr got %h want %h", i, obs_addr, {addr[31:2], 2'b00}); end
      n_cmp++; if (obs_we !== rw) begin n_bad++; $display("FAIL mix%0d_dm_we got %b want %b", i, obs_we, rw); end
      if (rw) begin
        n_cmp++; if (obs_wdata !== m_store_data(w, sd)) begin n_bad++; $display("FAIL mix%0d_wdata got %h want %h", i, obs_wdata, m_store_data(w, sd)); end
        n_cmp++; if (obs_wstrb !== m_strb(w, lsb)) begin n_bad++; $display("FAIL mix%0d_wstrb got %b want %b", i, obs_wstrb, m_strb(w, lsb)); end
      end
      check_pop($sformatf("mix%0d_%s_w%0d", i, rw ? "st" : "ld", w));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte();
    test_load_half_delayed();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
